mem_axi_seq: RTL and testbench

Sequences single load/store requests from the core's memory stage onto the AXI4-Lite master bus toward the MMU. Accepts one request at a time and generates byte/half/word write strobes and lane-replicated write data. Drives the AR/R or AW/W/B handshakes. Returns sign- or zero-extended load data with an error flag. It sits between the core's load/store unit and the core's top-level AXI4-Lite master ports.

---
 rtl/mem_axi_seq_if.sv | 57 +++++
 rtl/mem_axi_seq.sv | 227 ++++++++++++++++++++++
 tb/tb_mem_axi_seq.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_axi_seq_if.sv
// Bundle of the load/store request/response channel and the AXI4-Lite
// master channels for mem_axi_seq.
// The master modport is the sequencer's view. The slave modport is the view of
// whatever sits on the other side: the core LSU on the request side and the
// MMU on the AXI side.
interface mem_axi_seq_if;
   // Request / response channel toward the load/store unit
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;

   // AXI4-Lite read channels
   logic [31:0] axi_araddr;
   logic        axi_arvalid;
   logic        axi_arready;
   logic [31:0] axi_rdata;
   logic [1:0]  axi_rresp;
   logic        axi_rvalid;
   logic        axi_rready;

   // AXI4-Lite write channels
   logic [31:0] axi_awaddr;
   logic        axi_awvalid;
   logic        axi_awready;
   logic [31:0] axi_wdata;
   logic [3:0]  axi_wstrb;
   logic        axi_wvalid;
   logic        axi_wready;
   logic [1:0]  axi_bresp;
   logic        axi_bvalid;
   logic        axi_bready;

   modport master (
      input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
      input  axi_arready, axi_rdata, axi_rresp, axi_rvalid,
      input  axi_awready, axi_wready, axi_bresp, axi_bvalid,
      output req_ready, resp_valid, resp_rdata, resp_err,
      output axi_araddr, axi_arvalid, axi_rready,
      output axi_awaddr, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid, axi_bready
   );

   modport slave (
      output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
      output axi_arready, axi_rdata, axi_rresp, axi_rvalid,
      output axi_awready, axi_wready, axi_bresp, axi_bvalid,
      input  req_ready, resp_valid, resp_rdata, resp_err,
      input  axi_araddr, axi_arvalid, axi_rready,
      input  axi_awaddr, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid, axi_bready
   );
endinterface

// File: rtl/mem_axi_seq.sv
// mem_axi_seq: turns one load/store request at a time into an AXI4-Lite
// read (AR/R) or write (AW/W/B) transaction and returns extended load data.
//
// Handshake rule used on every channel: a transfer happens on a rising clock
// edge where valid and ready are both high; a valid, once raised, stays high
// with stable payload until that edge, and ready may be raised or lowered freely.
//
// Optional build macro: MEM_SEQ_MISALIGN_TRAP_EN. When it is defined, misaligned
// half/word requests are answered with an error and no bus access. When it is
// not defined, the misaligned low address bits are ignored for lane selection.
//
// dbg_state exposes the FSM state register (0 IDLE, 1 RD_ADDR, 2 RD_DATA,
// 3 WR_REQ, 4 WR_RESP).
module mem_axi_seq #(
   parameter int TIMEOUT = 1023
) (
   input  logic          clk,
   input  logic          rstn,
   mem_axi_seq_if.master bus,
   output logic [2:0]    dbg_state
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_ADDR = 3'd1,
      RD_DATA = 3'd2,
      WR_REQ  = 3'd3,
      WR_RESP = 3'd4
   } state_t;

   localparam int            CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam bit            WD_EN   = (TIMEOUT != 0);
   localparam logic [CW-1:0] WD_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

   state_t        state;
   logic [CW-1:0] wd_cnt;
   logic [1:0]    cap_size;
   logic          cap_signed;
   logic [1:0]    cap_lane;   // byte lane where the loaded item starts
   logic          aw_done;
   logic          w_done;

   logic          req_bad;
   logic [1:0]    lane_n;
   logic [3:0]    strb_n;
   logic [31:0]   wdata_n;
   logic [31:0]   shifted;
   logic [31:0]   load_n;
   logic          aw_hs;
   logic          w_hs;
   logic          wd_expire;

   assign dbg_state = state;
   assign aw_hs     = bus.axi_awvalid && bus.axi_awready;
   assign w_hs      = bus.axi_wvalid && bus.axi_wready;
   // The watchdog fires on the edge that would start the TIMEOUT+1-th cycle in a bus state.
   assign wd_expire = WD_EN && (state != IDLE) && (wd_cnt == WD_LAST);

   // Decode the incoming request: legality, starting lane, strobes and replicated write data.
   always_comb begin
      req_bad = (bus.req_size == 2'b11);
`ifdef MEM_SEQ_MISALIGN_TRAP_EN
      if ((bus.req_size == 2'b01) && bus.req_addr[0])
         req_bad = 1'b1;
      if ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00))
         req_bad = 1'b1;
`endif
      lane_n  = 2'b00;
      strb_n  = 4'b1111;
      wdata_n = bus.req_wdata;
      case (bus.req_size)
         2'b00: begin
            lane_n  = bus.req_addr[1:0];
            strb_n  = 4'b0001 << bus.req_addr[1:0];
            wdata_n = {4{bus.req_wdata[7:0]}};
         end
         2'b01: begin
            // addr[0] is ignored: a half always occupies lanes 0-1 or 2-3.
            lane_n  = {bus.req_addr[1], 1'b0};
            strb_n  = bus.req_addr[1] ? 4'b1100 : 4'b0011;
            wdata_n = {2{bus.req_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   // Align read data to bit 0, then mask and sign/zero-extend to the captured size.
   always_comb begin
      shifted = bus.axi_rdata >> {cap_lane, 3'b000};
      case (cap_size)
         2'b00:   load_n = cap_signed ? {{24{shifted[7]}}, shifted[7:0]}
                                      : {24'd0, shifted[7:0]};
         2'b01:   load_n = cap_signed ? {{16{shifted[15]}}, shifted[15:0]}
                                      : {16'd0, shifted[15:0]};
         default: load_n = shifted;
      endcase
   end

   // Sequencer FSM with registered bus/response outputs and the watchdog counter.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state           <= IDLE;
         wd_cnt          <= '0;
         cap_size        <= 2'b00;
         cap_signed      <= 1'b0;
         cap_lane        <= 2'b00;
         aw_done         <= 1'b0;
         w_done          <= 1'b0;
         bus.req_ready   <= 1'b1;
         bus.resp_valid  <= 1'b0;
         bus.resp_rdata  <= '0;
         bus.resp_err    <= 1'b0;
         bus.axi_araddr  <= '0;
         bus.axi_arvalid <= 1'b0;
         bus.axi_rready  <= 1'b0;
         bus.axi_awaddr  <= '0;
         bus.axi_awvalid <= 1'b0;
         bus.axi_wdata   <= '0;
         bus.axi_wstrb   <= 4'b0000;
         bus.axi_wvalid  <= 1'b0;
         bus.axi_bready  <= 1'b0;
      end else begin
         // The response is a single-cycle pulse; data and error are only meaningful with it.
         bus.resp_valid <= 1'b0;
         bus.resp_rdata <= '0;
         bus.resp_err   <= 1'b0;
         if (state != IDLE)
            wd_cnt <= wd_cnt + 1'b1;

         if (wd_expire) begin
            state           <= IDLE;
            wd_cnt          <= '0;
            aw_done         <= 1'b0;
            w_done          <= 1'b0;
            bus.axi_arvalid <= 1'b0;
            bus.axi_rready  <= 1'b0;
            bus.axi_awvalid <= 1'b0;
            bus.axi_wvalid  <= 1'b0;
            bus.axi_bready  <= 1'b0;
            bus.req_ready   <= 1'b1;
            bus.resp_valid  <= 1'b1;
            bus.resp_err    <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  wd_cnt <= '0;
                  if (bus.req_valid) begin
                     cap_size   <= bus.req_size;
                     cap_signed <= bus.req_signed;
                     cap_lane   <= lane_n;
                     if (req_bad) begin
                        // Rejected without touching the bus; stay ready for the next request.
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= 1'b1;
                     end else if (bus.req_we) begin
                        state           <= WR_REQ;
                        bus.req_ready   <= 1'b0;
                        bus.axi_awaddr  <= bus.req_addr;
                        bus.axi_awvalid <= 1'b1;
                        bus.axi_wdata   <= wdata_n;
                        bus.axi_wstrb   <= strb_n;
                        bus.axi_wvalid  <= 1'b1;
                        aw_done         <= 1'b0;
                        w_done          <= 1'b0;
                     end else begin
                        state           <= RD_ADDR;
                        bus.req_ready   <= 1'b0;
                        bus.axi_araddr  <= bus.req_addr;
                        bus.axi_arvalid <= 1'b1;
                     end
                  end
               end
               RD_ADDR: begin
                  if (bus.axi_arready) begin
                     state           <= RD_DATA;
                     wd_cnt          <= '0;
                     bus.axi_arvalid <= 1'b0;
                     bus.axi_rready  <= 1'b1;
                  end
               end
               RD_DATA: begin
                  if (bus.axi_rvalid) begin
                     state          <= IDLE;
                     bus.axi_rready <= 1'b0;
                     bus.req_ready  <= 1'b1;
                     bus.resp_valid <= 1'b1;
                     bus.resp_err   <= (bus.axi_rresp != 2'b00);
                     bus.resp_rdata <= (bus.axi_rresp == 2'b00) ? load_n : 32'd0;
                  end
               end
               WR_REQ: begin
                  // AW and W complete independently; each valid drops after its own transfer.
                  if (aw_hs) begin
                     bus.axi_awvalid <= 1'b0;
                     aw_done         <= 1'b1;
                  end
                  if (w_hs) begin
                     bus.axi_wvalid <= 1'b0;
                     w_done         <= 1'b1;
                  end
                  if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                     state          <= WR_RESP;
                     wd_cnt         <= '0;
                     aw_done        <= 1'b0;
                     w_done         <= 1'b0;
                     bus.axi_bready <= 1'b1;
                  end
               end
               WR_RESP: begin
                  if (bus.axi_bvalid) begin
                     state          <= IDLE;
                     bus.axi_bready <= 1'b0;
                     bus.req_ready  <= 1'b1;
                     bus.resp_valid <= 1'b1;
                     bus.resp_err   <= (bus.axi_bresp != 2'b00);
                  end
               end
               default: begin
                  state         <= IDLE;
                  bus.req_ready <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mem_axi_seq.sv
// Self-checking bench for mem_axi_seq: a directed vector table with literal
// expectations, hand-written watchdog/reset sequences, and randomized
// transactions checked against an arithmetic reference model.
module tb_mem_axi_seq;

   localparam int TIMEOUT = 32;
   localparam int LIMIT   = 200;

   logic       clk = 1'b0;
   logic       rstn;
   logic [2:0] dbg_state;

   mem_axi_seq_if bus();

   mem_axi_seq #(.TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end

   // ---------------- bookkeeping ----------------
   int checks   = 0;
   int failures = 0;
   logic [32:0] exp_q[$];   // scoreboard: {resp_err, resp_rdata}

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   typedef struct {
      bit          got;
      int          lat;
      logic [31:0] rdata;
      logic        err;
      int          ar_cyc;
      int          r_cyc;
      int          aw_cyc;
      int          w_cyc;
      int          b_cyc;
      logic [3:0]  strb;
      logic [31:0] wd;
      logic [31:0] araddr;
      logic [31:0] awaddr;
   } obs_t;

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic [1:0]  rsp;
      int          aw_d;
      int          w_d;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
      logic [3:0]  exp_strb;
      logic [31:0] exp_wdata;
   } vec_t;

   function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sgn,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] rdata, input logic [1:0] rsp,
                               input int aw_d, input int w_d, input logic [31:0] exp_rdata,
                               input logic exp_err, input int exp_lat,
                               input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
      vec_t v;
      v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
      v.rdata = rdata; v.rsp = rsp; v.aw_d = aw_d; v.w_d = w_d;
      v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
      v.exp_strb = exp_strb; v.exp_wdata = exp_wdata;
      return v;
   endfunction

   // ---------------- reference model ----------------
   function automatic bit model_reject(input logic [1:0] size, input logic [31:0] addr);
      if (size == 2'd3) return 1'b1;
`ifdef MEM_SEQ_MISALIGN_TRAP_EN
      if (size == 2'd1 && (addr % 2) != 0) return 1'b1;
      if (size == 2'd2 && (addr % 4) != 0) return 1'b1;
`endif
      return 1'b0;
   endfunction

   // First byte lane of the item; misaligned low bits are dropped.
   function automatic int model_lane(input logic [1:0] size, input logic [31:0] addr);
      int a = int'(addr % 4);
      if (size == 2'd0) return a;
      if (size == 2'd1) return (a / 2) * 2;
      return 0;
   endfunction

   function automatic logic [31:0] model_load(input logic [1:0] size, input logic sgn,
                                              input logic [31:0] addr, input logic [31:0] rdata);
      int          n    = 1 << size;
      int          k    = model_lane(size, addr);
      logic [63:0] mask = (64'd1 << (8 * n)) - 64'd1;
      logic [63:0] v    = ({32'd0, rdata} >> (8 * k)) & mask;
      if (sgn && ((v >> (8 * n - 1)) & 64'd1) != 64'd0) v = v | ~mask;
      return v[31:0];
   endfunction

   function automatic logic [3:0] model_strb(input logic [1:0] size, input logic [31:0] addr);
      int         n = 1 << size;
      int         k = model_lane(size, addr);
      logic [3:0] s = '0;
      for (int i = 0; i < 4; i++) s[i] = (i >= k) && (i < k + n);
      return s;
   endfunction

   function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] wdata);
      int          n = 1 << size;
      logic [31:0] w = '0;
      for (int i = 0; i < 4; i++) w[8*i +: 8] = wdata[8*(i % n) +: 8];
      return w;
   endfunction

   // ---------------- driver: request + reactive AXI slave ----------------
   task automatic clear_slave();
      bus.axi_arready = 1'b0;
      bus.axi_rvalid  = 1'b0;
      bus.axi_awready = 1'b0;
      bus.axi_wready  = 1'b0;
      bus.axi_bvalid  = 1'b0;
   endtask

   // Called at a negedge; returns at the negedge of the resp_valid cycle.
   task automatic run_txn(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input logic [1:0] rsp,
                          input int ar_d, input int r_d, input int aw_d, input int w_d,
                          input int b_d, output obs_t o);
      o.got = 1'b0; o.lat = 0; o.rdata = '0; o.err = 1'b0;
      o.ar_cyc = 0; o.r_cyc = 0; o.aw_cyc = 0; o.w_cyc = 0; o.b_cyc = 0;
      o.strb = '0; o.wd = '0; o.araddr = '0; o.awaddr = '0;
      check("accept_ready", 32'(bus.req_ready), 32'd1);
      clear_slave();
      bus.axi_rdata  = rdata;
      bus.axi_rresp  = rsp;
      bus.axi_bresp  = rsp;
      bus.req_we     = we;
      bus.req_size   = size;
      bus.req_signed = sgn;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      bus.req_valid  = 1'b1;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      for (int cyc = 1; cyc <= LIMIT; cyc++) begin
         @(negedge clk);
         if (bus.resp_valid) begin
            o.got   = 1'b1;
            o.lat   = cyc;
            o.rdata = bus.resp_rdata;
            o.err   = bus.resp_err;
            clear_slave();
            break;
         end
         if (bus.axi_arvalid) begin o.ar_cyc++; o.araddr = bus.axi_araddr; end
         if (bus.axi_rready)  o.r_cyc++;
         if (bus.axi_awvalid) begin o.aw_cyc++; o.awaddr = bus.axi_awaddr; end
         if (bus.axi_wvalid)  begin o.w_cyc++; o.strb = bus.axi_wstrb; o.wd = bus.axi_wdata; end
         if (bus.axi_bready)  o.b_cyc++;
         bus.axi_arready = bus.axi_arvalid && (o.ar_cyc > ar_d);
         bus.axi_rvalid  = bus.axi_rready  && (o.r_cyc  > r_d);
         bus.axi_awready = bus.axi_awvalid && (o.aw_cyc > aw_d);
         bus.axi_wready  = bus.axi_wvalid  && (o.w_cyc  > w_d);
         bus.axi_bvalid  = bus.axi_bready  && (o.b_cyc  > b_d);
      end
      if (!o.got) begin
         checks++;
         failures++;
         $display("FAIL resp_wait actual=no_resp_in_%0d_cycles required=resp_valid", LIMIT);
      end
   endtask

   task automatic check_resp(input string tag, input obs_t o);
      logic [32:0] e;
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s_scoreboard actual=empty required=entry", tag);
         return;
      end
      e = exp_q.pop_front();
      check({tag, "_err"}, 32'(o.err), 32'(e[32]));
      check({tag, "_rdata"}, o.rdata, e[31:0]);
   endtask

   task automatic check_bus(input string tag, input logic we, input logic [31:0] addr,
                            input int exp_lat, input logic [3:0] exp_strb,
                            input logic [31:0] exp_wdata, input int ar_d, input int aw_d,
                            input int w_d, input obs_t o);
      check({tag, "_lat"}, 32'(o.lat), 32'(exp_lat));
      if (exp_lat == 1) begin
         check({tag, "_no_bus"}, 32'(o.ar_cyc + o.aw_cyc + o.w_cyc), 32'd0);
      end else if (we) begin
         check({tag, "_wstrb"}, 32'(o.strb), 32'(exp_strb));
         check({tag, "_wdata"}, o.wd, exp_wdata);
         check({tag, "_awaddr"}, o.awaddr, addr);
         check({tag, "_aw_cycles"}, 32'(o.aw_cyc), 32'(aw_d + 1));
         check({tag, "_w_cycles"}, 32'(o.w_cyc), 32'(w_d + 1));
      end else begin
         check({tag, "_araddr"}, o.araddr, addr);
         check({tag, "_ar_cycles"}, 32'(o.ar_cyc), 32'(ar_d + 1));
      end
   endtask

   // ---------------- main test ----------------
   initial begin
      vec_t        vecs[$];
      obs_t        o;
      logic        we, sgn, rej;
      logic [1:0]  size, rsp;
      logic [31:0] addr, wdata, rdata, e_rdata;
      int          ar_d, r_d, aw_d, w_d, b_d, e_lat;

      // Directed vectors with hand-computed expectations.
      vecs.push_back(mk(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 2'b00, 0, 0, 32'hDEADBEEF, 1'b0, 3, 4'h0, 32'h0));
      vecs.push_back(mk(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80FF1234, 2'b00, 0, 0, 32'hFFFFFF80, 1'b0, 3, 4'h0, 32'h0));
      vecs.push_back(mk(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80FF1234, 2'b00, 0, 0, 32'h00000080, 1'b0, 3, 4'h0, 32'h0));
      vecs.push_back(mk(1'b1, 2'd1, 1'b0, 32'h202, 32'h0000ABCD, 32'h0, 2'b00, 0, 1, 32'h0, 1'b0, 4, 4'b1100, 32'hABCDABCD));
      vecs.push_back(mk(1'b1, 2'd2, 1'b0, 32'h300, 32'h12345678, 32'h0, 2'b10, 0, 0, 32'h0, 1'b1, 3, 4'b1111, 32'h12345678));
      vecs.push_back(mk(1'b1, 2'd0, 1'b0, 32'h001, 32'hFFFFFF5A, 32'h0, 2'b00, 2, 0, 32'h0, 1'b0, 5, 4'b0010, 32'h5A5A5A5A));
      vecs.push_back(mk(1'b0, 2'd1, 1'b1, 32'h002, 32'h0, 32'h80010000, 2'b00, 0, 0, 32'hFFFF8001, 1'b0, 3, 4'h0, 32'h0));
      vecs.push_back(mk(1'b0, 2'd2, 1'b0, 32'h010, 32'h0, 32'hCAFEF00D, 2'b11, 0, 0, 32'h0, 1'b1, 3, 4'h0, 32'h0));
      vecs.push_back(mk(1'b0, 2'd3, 1'b0, 32'h020, 32'h0, 32'h12345678, 2'b00, 0, 0, 32'h0, 1'b1, 1, 4'h0, 32'h0));
`ifdef MEM_SEQ_MISALIGN_TRAP_EN
      vecs.push_back(mk(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 32'h11223344, 2'b00, 0, 0, 32'h0, 1'b1, 1, 4'h0, 32'h0));
      vecs.push_back(mk(1'b0, 2'd1, 1'b0, 32'h003, 32'h0, 32'hAABBCCDD, 2'b00, 0, 0, 32'h0, 1'b1, 1, 4'h0, 32'h0));
      vecs.push_back(mk(1'b1, 2'd2, 1'b0, 32'h102, 32'h01020304, 32'h0, 2'b00, 0, 0, 32'h0, 1'b1, 1, 4'h0, 32'h0));
      vecs.push_back(mk(1'b1, 2'd1, 1'b0, 32'h001, 32'h00001234, 32'h0, 2'b00, 0, 0, 32'h0, 1'b1, 1, 4'h0, 32'h0));
`else
      vecs.push_back(mk(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 32'h11223344, 2'b00, 0, 0, 32'h11223344, 1'b0, 3, 4'h0, 32'h0));
      vecs.push_back(mk(1'b0, 2'd1, 1'b0, 32'h003, 32'h0, 32'hAABBCCDD, 2'b00, 0, 0, 32'h0000AABB, 1'b0, 3, 4'h0, 32'h0));
      vecs.push_back(mk(1'b1, 2'd2, 1'b0, 32'h102, 32'h01020304, 32'h0, 2'b00, 0, 0, 32'h0, 1'b0, 3, 4'b1111, 32'h01020304));
      vecs.push_back(mk(1'b1, 2'd1, 1'b0, 32'h001, 32'h00001234, 32'h0, 2'b00, 0, 0, 32'h0, 1'b0, 3, 4'b0011, 32'h12341234));
`endif

      // Reset and idle bus.
      rstn           = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_size   = 2'b00;
      bus.req_signed = 1'b0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      bus.axi_rdata  = '0;
      bus.axi_rresp  = 2'b00;
      bus.axi_bresp  = 2'b00;
      clear_slave();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_req_ready", 32'(bus.req_ready), 32'd1);
      check("reset_valids", 32'({bus.axi_arvalid, bus.axi_rready, bus.axi_awvalid,
                                 bus.axi_wvalid, bus.axi_bready, bus.resp_valid}), 32'd0);
      check("reset_rdata_err", bus.resp_rdata | 32'(bus.resp_err), 32'd0);
      check("reset_wstrb", 32'(bus.axi_wstrb), 32'd0);
      check("reset_state", 32'(dbg_state), 32'd0);
      rstn = 1'b1;

      // Table-driven vectors; consecutive calls also exercise back-to-back acceptance.
      for (int i = 0; i < vecs.size(); i++) begin
         exp_q.push_back({vecs[i].exp_err, vecs[i].exp_rdata});
         run_txn(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
                 vecs[i].rdata, vecs[i].rsp, 0, 0, vecs[i].aw_d, vecs[i].w_d, 0, o);
         check_resp($sformatf("vec%0d", i), o);
         check_bus($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].exp_lat,
                   vecs[i].exp_strb, vecs[i].exp_wdata, 0, vecs[i].aw_d, vecs[i].w_d, o);
      end

      // Watchdog on a stuck AR channel.
      exp_q.push_back({1'b1, 32'h0});
      run_txn(1'b0, 2'd2, 1'b0, 32'h500, 32'h0, 32'h77777777, 2'b00, 1000, 0, 0, 0, 0, o);
      check_resp("wd_ar", o);
      check("wd_ar_lat", 32'(o.lat), 32'(TIMEOUT + 1));
      check("wd_ar_cycles", 32'(o.ar_cyc), 32'(TIMEOUT));
      check("wd_ar_dropped", 32'(bus.axi_arvalid), 32'd0);
      check("wd_ar_req_ready", 32'(bus.req_ready), 32'd1);

      // Watchdog on a stuck B channel.
      exp_q.push_back({1'b1, 32'h0});
      run_txn(1'b1, 2'd2, 1'b0, 32'h600, 32'h55AA55AA, 32'h0, 2'b00, 0, 0, 0, 0, 1000, o);
      check_resp("wd_b", o);
      check("wd_b_lat", 32'(o.lat), 32'(TIMEOUT + 2));
      check("wd_b_cycles", 32'(o.b_cyc), 32'(TIMEOUT));
      check("wd_b_dropped", 32'(bus.axi_bready), 32'd0);

      // Asynchronous reset in the middle of RD_DATA.
      clear_slave();
      bus.req_we    = 1'b0;
      bus.req_size  = 2'd2;
      bus.req_addr  = 32'h40;
      bus.req_valid = 1'b1;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(negedge clk);
      check("mid_arvalid", 32'(bus.axi_arvalid), 32'd1);
      bus.axi_arready = 1'b1;
      @(negedge clk);
      bus.axi_arready = 1'b0;
      check("mid_rready", 32'(bus.axi_rready), 32'd1);
      #2 rstn = 1'b0;
      #1;
      check("mid_rst_rready", 32'(bus.axi_rready), 32'd0);
      check("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);
      check("mid_rst_state", 32'(dbg_state), 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      exp_q.push_back({1'b0, 32'h0BADF00D});
      run_txn(1'b0, 2'd2, 1'b0, 32'h44, 32'h0, 32'h0BADF00D, 2'b00, 0, 0, 0, 0, 0, o);
      check_resp("post_rst", o);
      check("post_rst_lat", 32'(o.lat), 32'd3);

      // Randomized transactions against the reference model.
      for (int n = 0; n < 150; n++) begin
         we    = 1'($urandom_range(0, 1));
         size  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         sgn   = 1'($urandom_range(0, 1));
         addr  = $urandom;
         wdata = $urandom;
         rdata = $urandom;
         rsp   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         ar_d  = $urandom_range(0, 3);
         r_d   = $urandom_range(0, 3);
         aw_d  = $urandom_range(0, 3);
         w_d   = $urandom_range(0, 3);
         b_d   = $urandom_range(0, 3);
         rej   = model_reject(size, addr);
         if (rej)
            e_lat = 1;
         else if (we)
            e_lat = 3 + ((aw_d > w_d) ? aw_d : w_d) + b_d;
         else
            e_lat = 3 + ar_d + r_d;
         e_rdata = (rej || we || rsp != 2'b00) ? 32'h0 : model_load(size, sgn, addr, rdata);
         exp_q.push_back({rej || (rsp != 2'b00), e_rdata});
         run_txn(we, size, sgn, addr, wdata, rdata, rsp, ar_d, r_d, aw_d, w_d, b_d, o);
         check_resp($sformatf("rnd%0d", n), o);
         check_bus($sformatf("rnd%0d", n), we, addr, e_lat, model_strb(size, addr),
                   model_wdata(size, wdata), ar_d, aw_d, w_d, o);
      end

      // The last response pulse must end after one cycle.
      @(negedge clk);
      check("resp_pulse_end", 32'(bus.resp_valid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
